// File: rtl/cpu_pkg.sv
// Shared types and constants for the instruction-sequencing controller:
// the FSM state enum, opcodes, ALU select codes and instruction field positions.
package cpu_pkg;

   localparam int unsigned PC_W = 7;   // program counter / instruction address width
   localparam int unsigned IW   = 16;  // instruction width

   // Instruction field MSB positions; each field is taken with [MSB -: width]
   localparam int unsigned FLD_OP      = 15;  // opcode, 4 bits
   localparam int unsigned FLD_RA      = 11;  // rA for STORE/ADD/SUB, 4 bits
   localparam int unsigned FLD_RB      = 7;   // rB for ADD/SUB, 4 bits
   localparam int unsigned FLD_RQ      = 3;   // rQ for ADD/SUB, 4 bits
   localparam int unsigned FLD_LD_ADDR = 11;  // LOAD address, 8 bits
   localparam int unsigned FLD_LD_RA   = 3;   // LOAD destination, 4 bits
   localparam int unsigned FLD_ST_ADDR = 7;   // STORE address, 8 bits

   localparam int unsigned OP_W   = 4;
   localparam int unsigned REG_W  = 4;
   localparam int unsigned DADR_W = 8;
   localparam int unsigned ALU_W  = 3;

   localparam logic [OP_W-1:0] OP_NOOP  = 4'b0000;
   localparam logic [OP_W-1:0] OP_STORE = 4'b0001;
   localparam logic [OP_W-1:0] OP_LOAD  = 4'b0010;
   localparam logic [OP_W-1:0] OP_ADD   = 4'b0011;
   localparam logic [OP_W-1:0] OP_SUB   = 4'b0100;
   localparam logic [OP_W-1:0] OP_HALT  = 4'b0101;

   localparam logic [ALU_W-1:0] ALU_ZERO = 3'b000;
   localparam logic [ALU_W-1:0] ALU_ADD  = 3'b001;
   localparam logic [ALU_W-1:0] ALU_SUB  = 3'b010;

   typedef enum logic [3:0] {
      S_INIT   = 4'd0,
      S_FETCH  = 4'd1,
      S_DECODE = 4'd2,
      S_LOAD_A = 4'd3,
      S_LOAD_B = 4'd4,
      S_STORE  = 4'd5,
      S_ADD    = 4'd6,
      S_SUB    = 4'd7,
      S_HALT   = 4'd8
   } state_t;

   // Opcode field of an instruction word
   function automatic logic [OP_W-1:0] opcode(input logic [IW-1:0] instr);
      return instr[FLD_OP -: OP_W];
   endfunction

endpackage

// File: rtl/control_unit_if.sv
// Bus between the controller, the instruction ROM and the datapath.
//   master : controller side (drives ROM address/read and datapath controls)
//   slave  : ROM/datapath side (returns IM_data)
interface control_unit_if;
   import cpu_pkg::*;

   logic [PC_W-1:0]   PC_addr;
   logic              IM_rd;
   logic [IW-1:0]     IM_data;
   logic [DADR_W-1:0] D_Addr;
   logic              D_wr;
   logic              RF_s;
   logic [REG_W-1:0]  RF_W_addr;
   logic              RF_W_en;
   logic [REG_W-1:0]  RF_Ra_addr;
   logic [REG_W-1:0]  RF_Rb_addr;
   logic [ALU_W-1:0]  Alu_s0;
   logic [3:0]        state_out;

   modport master (
      output PC_addr, IM_rd, D_Addr, D_wr, RF_s, RF_W_addr, RF_W_en,
             RF_Ra_addr, RF_Rb_addr, Alu_s0, state_out,
      input  IM_data
   );

   modport slave (
      input  PC_addr, IM_rd, D_Addr, D_wr, RF_s, RF_W_addr, RF_W_en,
             RF_Ra_addr, RF_Rb_addr, Alu_s0, state_out,
      output IM_data
   );

endinterface

// File: rtl/pc_ir.sv
// Program counter and instruction register.
//   clk, reset : clock, asynchronous active-high reset (PC=0, IR=0)
//   i_pc_clr   : load PC with zero
//   i_pc_inc   : increment PC (wraps at 2^PC_W)
//   i_ir_ld    : load IR from i_ir_d
//   o_pc, o_ir : current PC and IR
module pc_ir
   import cpu_pkg::*;
(
   input  logic            clk,
   input  logic            reset,
   input  logic            i_pc_clr,
   input  logic            i_pc_inc,
   input  logic            i_ir_ld,
   input  logic [IW-1:0]   i_ir_d,
   output logic [PC_W-1:0] o_pc,
   output logic [IW-1:0]   o_ir
);

   logic [PC_W-1:0] r_pc;
   logic [IW-1:0]   r_ir;

   // PC: clear has priority over increment; natural wrap at the top
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_pc <= '0;
      end else if (i_pc_clr) begin
         r_pc <= '0;
      end else if (i_pc_inc) begin
         r_pc <= r_pc + PC_W'(1);
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_ir <= '0;
      end else if (i_ir_ld) begin
         r_ir <= i_ir_d;
      end
   end

   assign o_pc = r_pc;
   assign o_ir = r_ir;

endmodule

// File: rtl/control_unit.sv
// Fetch/decode/execute sequencer driving the datapath control inputs.
//   clk, reset : clock, asynchronous active-high reset
//   bus        : master side of control_unit_if
//                (PC_addr/IM_rd to ROM, IM_data from ROM, datapath controls,
//                 state_out debug code)
// Controls are Moore outputs decoded from the state and IR registers, so an
// asynchronous reset clears them immediately.
module control_unit
   import cpu_pkg::*;
(
   input  logic          clk,
   input  logic          reset,
   control_unit_if.master bus
);

   state_t          r_state;
   logic [PC_W-1:0] w_pc;
   logic [IW-1:0]   w_ir;
   logic [OP_W-1:0] w_im_op;
   logic            w_pc_clr;
   logic            w_pc_inc;
   logic            w_ir_ld;
   logic            w_unused_ir_op;

   assign w_pc_clr = (r_state == S_INIT);
   assign w_pc_inc = (r_state == S_FETCH);
   assign w_ir_ld  = (r_state == S_DECODE);

   // Decode reads the ROM word directly; IR only becomes valid after this edge
   assign w_im_op = opcode(bus.IM_data);

   // IR opcode bits are not needed once the state encodes the instruction
   assign w_unused_ir_op = ^w_ir[FLD_OP -: OP_W];

   pc_ir u_pc_ir (
      .clk      (clk),
      .reset    (reset),
      .i_pc_clr (w_pc_clr),
      .i_pc_inc (w_pc_inc),
      .i_ir_ld  (w_ir_ld),
      .i_ir_d   (bus.IM_data),
      .o_pc     (w_pc),
      .o_ir     (w_ir)
   );

   // State register with next-state selection
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_state <= S_INIT;
      end else begin
         case (r_state)
            S_INIT:   r_state <= S_FETCH;
            S_FETCH:  r_state <= S_DECODE;
            S_DECODE: begin
               case (w_im_op)
                  OP_NOOP:  r_state <= S_FETCH;
                  OP_LOAD:  r_state <= S_LOAD_A;
                  OP_STORE: r_state <= S_STORE;
                  OP_ADD:   r_state <= S_ADD;
                  OP_SUB:   r_state <= S_SUB;
                  OP_HALT:  r_state <= S_HALT;
                  default:  r_state <= S_FETCH;  // illegal opcodes act as NOOP
               endcase
            end
            S_LOAD_A: r_state <= S_LOAD_B;
            S_LOAD_B: r_state <= S_FETCH;
            S_STORE:  r_state <= S_FETCH;
            S_ADD:    r_state <= S_FETCH;
            S_SUB:    r_state <= S_FETCH;
            S_HALT:   r_state <= S_HALT;
            default:  r_state <= S_INIT;
         endcase
      end
   end

   // Moore output decode
   always_comb begin
      bus.PC_addr    = '0;
      bus.IM_rd      = 1'b0;
      bus.D_Addr     = '0;
      bus.D_wr       = 1'b0;
      bus.RF_s       = 1'b0;
      bus.RF_W_addr  = '0;
      bus.RF_W_en    = 1'b0;
      bus.RF_Ra_addr = '0;
      bus.RF_Rb_addr = '0;
      bus.Alu_s0     = ALU_ZERO;
      case (r_state)
         S_FETCH: begin
            bus.PC_addr = w_pc;
            bus.IM_rd   = 1'b1;
         end
         S_LOAD_A: begin
            // Address held one cycle ahead to cover the data-memory read latency
            bus.D_Addr = w_ir[FLD_LD_ADDR -: DADR_W];
            bus.RF_s   = 1'b1;
         end
         S_LOAD_B: begin
            bus.D_Addr    = w_ir[FLD_LD_ADDR -: DADR_W];
            bus.RF_s      = 1'b1;
            bus.RF_W_addr = w_ir[FLD_LD_RA -: REG_W];
            bus.RF_W_en   = 1'b1;
         end
         S_STORE: begin
            bus.D_Addr     = w_ir[FLD_ST_ADDR -: DADR_W];
            bus.RF_Ra_addr = w_ir[FLD_RA -: REG_W];
            bus.D_wr       = 1'b1;
         end
         S_ADD, S_SUB: begin
            bus.RF_Ra_addr = w_ir[FLD_RA -: REG_W];
            bus.RF_Rb_addr = w_ir[FLD_RB -: REG_W];
            bus.RF_W_addr  = w_ir[FLD_RQ -: REG_W];
            bus.RF_W_en    = 1'b1;
            bus.Alu_s0     = (r_state == S_ADD) ? ALU_ADD : ALU_SUB;
         end
         default: begin
         end
      endcase
   end

   assign bus.state_out = r_state;

endmodule

// File: tb/tb_control_unit.sv
// Bench for control_unit: a small program in a synchronous ROM model, with
// expected per-cycle output vectors queued as stimulus is set up and checked
// at each falling edge.
module tb_control_unit;

   logic clk   = 1'b0;
   logic reset = 1'b1;

   control_unit_if bus ();

   control_unit dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus)
   );

   always #5 clk = ~clk;

   // Synchronous instruction ROM, one-cycle read latency
   logic [15:0] rom [0:127];
   always @(posedge clk) begin
      if (bus.IM_rd) bus.IM_data <= rom[bus.PC_addr];
   end

   // {state, PC_addr, IM_rd, D_Addr, D_wr, RF_s, W_addr, W_en, Ra, Rb, Alu}
   typedef logic [37:0] vec_t;
   vec_t sb[$];
   int   n_vec = 0;
   int   n_err = 0;

   function automatic vec_t v(input int st, input int pc, input int rd,
                              input int da, input int dw, input int rs,
                              input int wa, input int we, input int ra,
                              input int rb, input int alu);
      return {4'(st), 7'(pc), 1'(rd), 8'(da), 1'(dw), 1'(rs),
              4'(wa), 1'(we), 4'(ra), 4'(rb), 3'(alu)};
   endfunction

   function automatic vec_t act();
      return {bus.state_out, bus.PC_addr, bus.IM_rd, bus.D_Addr, bus.D_wr,
              bus.RF_s, bus.RF_W_addr, bus.RF_W_en, bus.RF_Ra_addr,
              bus.RF_Rb_addr, bus.Alu_s0};
   endfunction

   function automatic vec_t z();     return v(0,0,0,0,0,0,0,0,0,0,0); endfunction
   function automatic vec_t fe(input int pc); return v(1,pc,1,0,0,0,0,0,0,0,0); endfunction
   function automatic vec_t dec();   return v(2,0,0,0,0,0,0,0,0,0,0); endfunction

   task automatic test_reset();
      vec_t got, exp;
      reset = 1'b1;
      for (int i = 0; i < 3; i++) sb.push_back(z());
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         got = act(); exp = sb.pop_front(); n_vec++;
         if (got !== exp) begin
            n_err++;
            $display("FAIL reset_hold cyc%0d got=%h exp=%h", i, got, exp);
         end
      end
      reset = 1'b0;
      sb.push_back(fe(0));
      sb.push_back(dec());
      for (int i = 0; i < 2; i++) begin
         @(negedge clk);
         got = act(); exp = sb.pop_front(); n_vec++;
         if (got !== exp) begin
            n_err++;
            $display("FAIL reset_release cyc%0d got=%h exp=%h", i, got, exp);
         end
      end
      n_vec++;
      if (dut.w_pc !== 7'd1) begin
         n_err++;
         $display("FAIL pc_after_fetch got=%0d exp=1", dut.w_pc);
      end
   endtask

   task automatic test_load();
      vec_t got, exp;
      sb.push_back(v(3,0,0,27,0,1,0,0,0,0,0));
      sb.push_back(v(4,0,0,27,0,1,1,1,0,0,0));
      sb.push_back(fe(1));
      sb.push_back(dec());
      for (int i = 0; i < 4; i++) begin
         @(negedge clk);
         got = act(); exp = sb.pop_front(); n_vec++;
         if (got !== exp) begin
            n_err++;
            $display("FAIL load cyc%0d got=%h exp=%h", i, got, exp);
         end
      end
   endtask

   task automatic test_arith(input int alu, input int next_pc);
      vec_t got, exp;
      sb.push_back(v(alu == 1 ? 6 : 7,0,0,0,0,0,3,1,1,2,alu));
      sb.push_back(fe(next_pc));
      sb.push_back(dec());
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         got = act(); exp = sb.pop_front(); n_vec++;
         if (got !== exp) begin
            n_err++;
            $display("FAIL arith_alu%0d cyc%0d got=%h exp=%h", alu, i, got, exp);
         end
      end
   endtask

   task automatic test_store();
      vec_t got, exp;
      sb.push_back(v(5,0,0,8'h10,1,0,0,0,3,0,0));
      sb.push_back(fe(3));
      sb.push_back(dec());
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         got = act(); exp = sb.pop_front(); n_vec++;
         if (got !== exp) begin
            n_err++;
            $display("FAIL store cyc%0d got=%h exp=%h", i, got, exp);
         end
      end
   endtask

   task automatic test_noop_illegal_halt();
      vec_t got, exp;
      sb.push_back(fe(4));    // after NOOP at ROM[3]
      sb.push_back(dec());
      sb.push_back(fe(5));    // after illegal F000 at ROM[4]
      sb.push_back(dec());
      for (int i = 0; i < 20; i++) sb.push_back(v(8,0,0,0,0,0,0,0,0,0,0));
      for (int i = 0; i < 24; i++) begin
         @(negedge clk);
         got = act(); exp = sb.pop_front(); n_vec++;
         if (got !== exp) begin
            n_err++;
            $display("FAIL noop_halt cyc%0d got=%h exp=%h", i, got, exp);
         end
         if (i >= 4) begin
            n_vec++;
            if (dut.w_pc !== 7'd6) begin
               n_err++;
               $display("FAIL halt_pc cyc%0d got=%0d exp=6", i, dut.w_pc);
            end
         end
      end
   endtask

   task automatic test_reset_mid_load();
      vec_t got, exp;
      rom[1] = 16'h4123;      // SUB r3=r1-r2 follows the re-fetched LOAD
      reset = 1'b1;
      sb.push_back(z());
      sb.push_back(z());
      for (int i = 0; i < 2; i++) begin
         @(negedge clk);
         got = act(); exp = sb.pop_front(); n_vec++;
         if (got !== exp) begin
            n_err++;
            $display("FAIL halt_reset cyc%0d got=%h exp=%h", i, got, exp);
         end
      end
      reset = 1'b0;
      sb.push_back(fe(0));
      sb.push_back(dec());
      sb.push_back(v(3,0,0,27,0,1,0,0,0,0,0));
      sb.push_back(v(4,0,0,27,0,1,1,1,0,0,0));
      for (int i = 0; i < 4; i++) begin
         @(negedge clk);
         got = act(); exp = sb.pop_front(); n_vec++;
         if (got !== exp) begin
            n_err++;
            $display("FAIL pre_abort cyc%0d got=%h exp=%h", i, got, exp);
         end
      end
      // Assert reset between edges: outputs must clear without a clock
      #2 reset = 1'b1;
      sb.push_back(z());
      #1;
      got = act(); exp = sb.pop_front(); n_vec++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL async_abort got=%h exp=%h", got, exp);
      end
      @(negedge clk);
      reset = 1'b0;
      sb.push_back(fe(0));
      sb.push_back(dec());
      sb.push_back(v(3,0,0,27,0,1,0,0,0,0,0));
      sb.push_back(v(4,0,0,27,0,1,1,1,0,0,0));
      sb.push_back(fe(1));
      sb.push_back(dec());
      for (int i = 0; i < 6; i++) begin
         @(negedge clk);
         got = act(); exp = sb.pop_front(); n_vec++;
         if (got !== exp) begin
            n_err++;
            $display("FAIL refetch cyc%0d got=%h exp=%h", i, got, exp);
         end
      end
   endtask

   initial begin
      for (int i = 0; i < 128; i++) rom[i] = 16'h0000;
      rom[0] = 16'h21B1;  // LOAD r1, addr 27
      rom[1] = 16'h3123;  // ADD r3 = r1 + r2
      rom[2] = 16'h1310;  // STORE r3 -> 0x10
      rom[3] = 16'h0000;  // NOOP
      rom[4] = 16'hF000;  // illegal, behaves as NOOP
      rom[5] = 16'h5000;  // HALT
      bus.IM_data = 16'h0000;

      test_reset();
      test_load();
      test_arith(1, 2);
      test_store();
      test_noop_illegal_halt();
      test_reset_mid_load();
      test_arith(2, 2);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
